oled_init_seq: RTL and testbench
================================

// Module: oled_init_seq
// PURPOSE
//  Power-up sequencer that sits directly upstream of the I2C master core in the OLED display top.
//  On a start pulse it does three things in order:
//   - generates the OLED hardware reset pulse;
//   - waits for the panel to settle;
//   - feeds the fixed SSD1306 128x64 init command string to the I2C master as one write transaction.
//  NACKs are retried; success or failure is reported as a level.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock, Hz
//  RESET_MS   10           reset-low time and post-reset settle time, ms; RST_CYC = CLK_FREQ/1000*RESET_MS
//  RETRY_MAX  3            transaction attempts before ERROR (>=1)
// PORTS
//  i_clk               in   1  system clock
//  i_rst               in   1  asynchronous, active-high reset
//  i_start             in   1  1-cycle pulse: run full init sequence
//  o_oled_rst          out  1  OLED reset pin, active low (0 = panel held in reset)
//  o_i2c_start         out  1  1-cycle pulse to master: begin write transaction
//  o_i2c_byte_cnt      out  8  bytes in transaction, constant 26
//  o_i2c_tx_data       out  8  current byte presented to master
//  i_i2c_tx_data_needed in  1  1-cycle pulse from master: current byte taken, present next
//  i_i2c_done          in   1  1-cycle pulse from master: transaction finished
//  i_i2c_nack          in   1  qualifies i_i2c_done: 1 = slave NACKed
//  o_busy              out  1  sequence in progress
//  o_done              out  1  init succeeded; held until next accepted i_start
//  o_error             out  1  retries exhausted; held until next accepted i_start
// BEHAVIOUR
//  Reset values:
//   - o_oled_rst=1
//   - o_i2c_start=0, o_i2c_tx_data=8'h00, o_i2c_byte_cnt=8'd26
//   - o_busy=0, o_done=0, o_error=0
//   - state IDLE, retry count 0
//  Byte stream (26 bytes): control byte 8'h00, then the ROM, index 0..24:
//   AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF
//  FSM:
//   - IDLE:   i_start -> RST_LO. Clear done/error and the retry count; o_busy=1.
//   - RST_LO: o_oled_rst=0 for exactly RST_CYC cycles -> RST_WT.
//   - RST_WT: o_oled_rst=1 for exactly RST_CYC cycles -> XFER.
//     Set o_i2c_tx_data=8'h00 and byte index 0, and pulse o_i2c_start for 1 cycle.
//   - XFER, on i_i2c_tx_data_needed:
//     - the next byte (ROM[index]) is registered onto o_i2c_tx_data on the following cycle;
//     - index increments;
//     - the byte stays stable until the next request.
//   - XFER, request after ROM[24] has been presented: ignored; o_i2c_tx_data holds 8'hAF.
//   - XFER, on i_i2c_done & ~i_i2c_nack -> DONE: o_done=1, o_busy=0.
//   - XFER, on i_i2c_done & i_i2c_nack: increment the retry count.
//     - If count < RETRY_MAX: re-enter XFER setup, starting a new transaction from byte 0.
//       The reset pulse is not repeated.
//     - Else -> ERROR: o_error=1, o_busy=0.
//   - DONE/ERROR: i_start -> RST_LO (same as from IDLE).
//  Other rules:
//   - i_start while o_busy=1 is ignored.
//   - i_i2c_done and i_i2c_tx_data_needed in the same cycle: done wins; the request is dropped.
//   - i_i2c_done outside XFER is ignored.
//   - The o_i2c_start pulse comes 1 cycle after RST_WT expiry; it is never asserted outside XFER entry.
//   - The delay counter width is $clog2(RST_CYC+1); it restarts from 0 on every state entry.
//   - i_rst asserted mid-sequence returns all outputs to reset values immediately (asynchronous).
//     No partial transaction is resumed.
// TESTING
//  - Use CLK_FREQ=1000, RESET_MS=10 (RST_CYC=10); the bench models the master.
//  - Nominal: i_start
//    -> o_oled_rst low for 10 cycles, then high for 10 cycles, then o_i2c_start pulse
//    -> byte_cnt=26, tx_data=00;
//    -> 25 requests return AE..AF in order; done with nack=0 gives o_done=1, o_busy=0.
//  - NACK retry: RETRY_MAX=3; nack on attempts 1 and 2, ack on attempt 3
//    -> three o_i2c_start pulses, only one reset pulse, o_done=1.
//  - Retry exhaustion: nack on every attempt
//    -> exactly 3 starts, then o_error=1, o_done=0, o_busy=0.
//  - Start while busy: i_start pulses during RST_LO and during XFER
//    -> no restart; reset-pulse timing and byte order unchanged.
//  - Reset mid-XFER after 7 bytes: i_rst
//    -> o_oled_rst=1, o_busy=0, tx_data=00 same cycle;
//    -> a following i_start gives a full fresh sequence.
//  - Overrun and collision: 26th request -> tx_data stays AF; done+request in the same cycle -> DONE, no index change.

Source files
------------

// File: rtl/oled_init_seq.sv
// Power-up sequencer for an SSD1306 128x64 OLED: hardware reset pulse, settle wait,
// then the init command string streamed to the I2C master as one write, with NACK retry.
module oled_init_seq #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int RESET_MS  = 10,
    parameter int RETRY_MAX = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_oled_rst,
    output logic       o_i2c_start,
    output logic [7:0] o_i2c_byte_cnt,
    output logic [7:0] o_i2c_tx_data,
    input  logic       i_i2c_tx_data_needed,
    input  logic       i_i2c_done,
    input  logic       i_i2c_nack,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam int RST_CYC = CLK_FREQ / 1000 * RESET_MS;
    localparam int CW      = $clog2(RST_CYC + 1);
    localparam int RW      = $clog2(RETRY_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(RST_CYC - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);
    localparam logic [4:0]    ROM_LEN    = 5'd25;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST_LO = 3'd1,
        S_RST_WT = 3'd2,
        S_XFER   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_retry;
    logic [4:0]      r_idx;
    logic            r_oled_rst;
    logic            r_i2c_start;
    logic [7:0]      r_tx_data;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    // SSD1306 init command bytes that follow the 8'h00 control byte.
    function automatic logic [7:0] rom_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'hAE;
            5'd1:  b = 8'hD5;
            5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;
            5'd4:  b = 8'h3F;
            5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;
            5'd7:  b = 8'h40;
            5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;
            5'd10: b = 8'h20;
            5'd11: b = 8'h00;
            5'd12: b = 8'hA1;
            5'd13: b = 8'hC8;
            5'd14: b = 8'hDA;
            5'd15: b = 8'h12;
            5'd16: b = 8'h81;
            5'd17: b = 8'hCF;
            5'd18: b = 8'hD9;
            5'd19: b = 8'hF1;
            5'd20: b = 8'hDB;
            5'd21: b = 8'h40;
            5'd22: b = 8'hA4;
            5'd23: b = 8'hA6;
            5'd24: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_idx       <= 5'd0;
            r_oled_rst  <= 1'b1;
            r_i2c_start <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_i2c_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state    <= S_RST_LO;
                        r_cnt      <= '0;
                        r_retry    <= '0;
                        r_oled_rst <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                S_RST_LO: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= S_RST_WT;
                        r_cnt      <= '0;
                        r_oled_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RST_WT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_XFER;
                        r_cnt       <= '0;
                        r_idx       <= 5'd0;
                        r_tx_data   <= 8'h00;
                        r_i2c_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_XFER: begin
                    // done takes priority over a same-cycle byte request
                    if (i_i2c_done) begin
                        if (!i_i2c_nack) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (r_retry < RETRY_LAST) begin
                            r_retry     <= r_retry + RW'(1);
                            r_idx       <= 5'd0;
                            r_tx_data   <= 8'h00;
                            r_i2c_start <= 1'b1;
                        end else begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (i_i2c_tx_data_needed && (r_idx < ROM_LEN)) begin
                        r_tx_data <= rom_byte(r_idx);
                        r_idx     <= r_idx + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_oled_rst     = r_oled_rst;
    assign o_i2c_start    = r_i2c_start;
    assign o_i2c_byte_cnt = 8'd26;
    assign o_i2c_tx_data  = r_tx_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule

// File: tb/tb_oled_init_seq.sv
// Randomized bench for oled_init_seq: the bench plays the I2C master and checks the
// sequencer against an expected byte list and a retry-outcome model.
module tb_oled_init_seq;

    localparam int RETRY_MAX = 3;
    localparam int RST_CYC   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       need;
    logic       done_in;
    logic       nack_in;
    logic       o_oled_rst;
    logic       o_i2c_start;
    logic [7:0] o_i2c_byte_cnt;
    logic [7:0] o_i2c_tx_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    int n_tests = 0;
    int n_fail  = 0;
    int starts_seen = 0;
    int rst_pulses  = 0;
    logic prev_oled = 1'b1;

    logic [7:0] rom [0:24] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                               8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                               8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                               8'hAF};

    oled_init_seq #(.CLK_FREQ(1000), .RESET_MS(10), .RETRY_MAX(RETRY_MAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start),
        .o_oled_rst(o_oled_rst), .o_i2c_start(o_i2c_start),
        .o_i2c_byte_cnt(o_i2c_byte_cnt), .o_i2c_tx_data(o_i2c_tx_data),
        .i_i2c_tx_data_needed(need), .i_i2c_done(done_in), .i_i2c_nack(nack_in),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    // Count start pulses and reset-pin falling edges between clock edges.
    always @(negedge clk) begin
        if (o_i2c_start) starts_seen++;
        if (prev_oled && !o_oled_rst) rst_pulses++;
        prev_oled = o_oled_rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start pulse, reset-low phase and settle phase; returns at the start-pulse sample.
    task automatic reset_phase(input bit inject);
        int n;
        int m;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        check("done_cleared", 32'(o_done), 32'd0);
        check("error_cleared", 32'(o_error), 32'd0);
        n = 0;
        while (o_oled_rst == 1'b0 && n < 100) begin
            n++;
            if (inject && n == 3) i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        check("rst_low_cycles", 32'(n), 32'(RST_CYC));
        m = 0;
        while (o_i2c_start == 1'b0 && m < 100) begin
            if (o_oled_rst == 1'b0) check("rst_high_during_wait", 32'(o_oled_rst), 32'd1);
            m++;
            tick();
        end
        check("rst_high_cycles", 32'(m), 32'(RST_CYC));
    endtask

    task automatic feed(input int nbytes, input bit inject);
        for (int k = 0; k < nbytes; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            need = 1'b1;
            if (inject && k == 5) i_start = 1'b1;
            tick();
            need = 1'b0;
            i_start = 1'b0;
            check($sformatf("byte%0d", k), 32'(o_i2c_tx_data), 32'(rom[k]));
        end
    endtask

    task automatic run_init(input bit inject_lo, input bit inject_xfer, input logic [2:0] nack_pat);
        int s0;
        int r0;
        int exp_starts;
        bit exp_ok;
        int nb;
        bit collide;
        // Outcome model: first acked attempt within the retry budget wins.
        exp_starts = RETRY_MAX;
        exp_ok = 1'b0;
        for (int a = RETRY_MAX - 1; a >= 0; a--) begin
            if (!nack_pat[a]) begin
                exp_starts = a + 1;
                exp_ok = 1'b1;
            end
        end
        s0 = starts_seen;
        r0 = rst_pulses;
        reset_phase(inject_lo);
        for (int a = 0; a < exp_starts; a++) begin
            check("start_pulse", 32'(o_i2c_start), 32'd1);
            check("tx_ctrl_byte", 32'(o_i2c_tx_data), 32'h00);
            check("byte_cnt", 32'(o_i2c_byte_cnt), 32'd26);
            check("busy_xfer", 32'(o_busy), 32'd1);
            tick();
            check("start_one_cycle", 32'(o_i2c_start), 32'd0);
            collide = ($urandom_range(0, 3) == 0);
            nb = collide ? int'($urandom_range(1, 24)) : 25;
            feed(nb, inject_xfer && a == 0);
            if (nb == 25 && $urandom_range(0, 1) == 1) begin
                need = 1'b1;
                tick();
                need = 1'b0;
                check("overrun_holds_AF", 32'(o_i2c_tx_data), 32'hAF);
            end
            repeat ($urandom_range(0, 2)) tick();
            done_in = 1'b1;
            nack_in = nack_pat[a];
            need = collide;
            tick();
            done_in = 1'b0;
            nack_in = 1'b0;
            need = 1'b0;
            if (a == exp_starts - 1) begin
                check("tx_after_done", 32'(o_i2c_tx_data), 32'(rom[nb-1]));
            end
        end
        check("done_level", 32'(o_done), 32'(exp_ok));
        check("error_level", 32'(o_error), 32'(!exp_ok));
        check("busy_end", 32'(o_busy), 32'd0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (3) tick();
        check("done_ignored_outside", 32'(o_done), 32'(exp_ok));
        check("start_count", 32'(starts_seen - s0), 32'(exp_starts));
        check("rst_pulse_count", 32'(rst_pulses - r0), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        need = 1'b0;
        done_in = 1'b0;
        nack_in = 1'b0;
        repeat (2) tick();
        check("rst_oled_rst", 32'(o_oled_rst), 32'd1);
        check("rst_start", 32'(o_i2c_start), 32'd0);
        check("rst_tx", 32'(o_i2c_tx_data), 32'h00);
        check("rst_byte_cnt", 32'(o_i2c_byte_cnt), 32'd26);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        rst = 1'b0;
        tick();

        run_init(1'b0, 1'b0, 3'b000);
        run_init(1'b0, 1'b0, 3'b011);
        run_init(1'b0, 1'b0, 3'b111);
        run_init(1'b1, 1'b1, 3'b000);
        run_init(1'b1, 1'b1, 3'($urandom_range(0, 7)));

        // Reset in the middle of a transfer, then a fresh sequence.
        reset_phase(1'b0);
        tick();
        feed(7, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_oled_rst", 32'(o_oled_rst), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_tx", 32'(o_i2c_tx_data), 32'h00);
        check("midrst_start", 32'(o_i2c_start), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_init(1'b0, 1'b0, 3'b000);

        for (int r = 0; r < 4; r++) begin
            run_init(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
